vdp_strobe: RTL and testbench

- Downstream consumer of the 6309E bus clocks (nE, nQ) produced by the CPLD clock generator.
- Decodes CPU accesses to the V9958 window and generates the VDP's active-low read and write strobes, timed to the E/Q phases.
- Enforces a minimum VDP recovery time between accesses by requesting a CPU wait.
- nWAIT_REQ is ANDed externally with the V9958's own nWAIT before it returns to the clock generator.

---
 rtl/kolibri_bus_pkg.sv | 14 +
 rtl/bus_phase_edge.sv | 29 ++
 rtl/vdp_strobe.sv | 131 +++++++++++++
 tb/tb_vdp_strobe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/kolibri_bus_pkg.sv
// Shared definitions for blocks timed off the 6309E E/Q bus phases.
package kolibri_bus_pkg;

  // MHZ48 cycles per E period (48 MHz / 3 MHz).
  localparam int unsigned ECycleLen = 16;

  // Bus-side access sequencing shared by E/Q-timed chip-select decoders.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StStrobe = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_phase_edge.sv
// Registers nE/nQ and flags the Q-rise and E-fall sampling edges.
// nE/nQ are generated in the MHZ48 domain, so no synchronizer is needed.
module bus_phase_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ne,
  input  logic i_nq,
  output logic o_qrise,
  output logic o_efall
);

  logic r_ne_d;
  logic r_nq_d;

  // Delay taps; reset high to match an idle bus so no edge fires on release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ne_d <= 1'b1;
      r_nq_d <= 1'b1;
    end else begin
      r_ne_d <= i_ne;
      r_nq_d <= i_nq;
    end
  end

  assign o_qrise = r_nq_d & ~i_nq;  // Q rising = nQ falling
  assign o_efall = ~r_ne_d & i_ne;  // E falling = nE rising

endmodule

// File: rtl/vdp_strobe.sv
// V9958 read/write strobe generator with enforced VDP recovery time.
// Strobes open on Q rise for a hit in the 4-byte VDP window and close on E fall.
// An access arriving inside the recovery window is stalled via nWAIT_REQ.
module vdp_strobe
  import kolibri_bus_pkg::*;
#(
  parameter logic [15:0] VDP_BASE        = 16'hFF60,
  parameter int unsigned RECOVERY_CYCLES = 48
) (
  input  logic        MHZ48,
  input  logic        RESET,
  input  logic        nE,
  input  logic        nQ,
  input  logic [15:0] ADDR,
  input  logic        RnW,
  output logic        nCSR,
  output logic        nCSW,
  output logic [1:0]  MODE,
  output logic        nWAIT_REQ
);

  localparam int unsigned CntW = $clog2(RECOVERY_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(RECOVERY_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (RECOVERY_CYCLES < 1) begin : g_bad_recovery
    $error("RECOVERY_CYCLES must be at least 1");
  end

  logic            w_qrise;
  logic            w_efall;
  logic            w_hit;
  logic            w_cnt_zero;

  bus_state_e      r_state;
  bus_state_e      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic [1:0]      r_mode;
  logic [1:0]      w_mode_d;
  logic            r_rnw;
  logic            w_rnw_d;
  logic            r_ncsr;
  logic            w_ncsr_d;
  logic            r_ncsw;
  logic            w_ncsw_d;
  logic            r_nwait;
  logic            w_nwait_d;

  bus_phase_edge u_phase (
    .i_clk   (MHZ48),
    .i_rst   (RESET),
    .i_ne    (nE),
    .i_nq    (nQ),
    .o_qrise (w_qrise),
    .o_efall (w_efall)
  );

  assign w_hit      = (ADDR[15:2] == VDP_BASE[15:2]);
  assign w_cnt_zero = (r_cnt == '0);

  // State register: FSM, recovery counter, latched access info and registered outputs.
  always_ff @(posedge MHZ48 or posedge RESET) begin
    if (RESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_rnw   <= 1'b1;
      r_ncsr  <= 1'b1;
      r_ncsw  <= 1'b1;
      r_nwait <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_mode  <= w_mode_d;
      r_rnw   <= w_rnw_d;
      r_ncsr  <= w_ncsr_d;
      r_ncsw  <= w_ncsw_d;
      r_nwait <= w_nwait_d;
    end
  end

  // Next-state: decode on Q rise, stall while recovering, close on E fall.
  always_comb begin
    w_state_d = r_state;
    w_mode_d  = r_mode;
    w_rnw_d   = r_rnw;
    w_cnt_d   = w_cnt_zero ? r_cnt : r_cnt - CntOne;
    unique case (r_state)
      StIdle: begin
        if (w_qrise && w_hit) begin
          w_mode_d  = ADDR[1:0];
          w_rnw_d   = RnW;
          w_state_d = w_cnt_zero ? StStrobe : StWait;
        end
      end
      StWait: begin
        // E falling while stalled means the clock generator ignored the wait:
        // drop the access and let the countdown run on.
        if (w_efall) begin
          w_state_d = StIdle;
        end else if (r_cnt <= CntOne) begin
          // <= covers entry with the counter already at 1 (enters WAIT at 0).
          w_state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (w_efall) begin
          w_state_d = StIdle;
          w_cnt_d   = CntLoad;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs: registered decode of the next state so strobes change on the deciding edge.
  always_comb begin
    w_ncsr_d  = ~((w_state_d == StStrobe) & w_rnw_d);
    w_ncsw_d  = ~((w_state_d == StStrobe) & ~w_rnw_d);
    w_nwait_d = (w_state_d != StWait);
  end

  assign nCSR      = r_ncsr;
  assign nCSW      = r_ncsw;
  assign MODE      = r_mode;
  assign nWAIT_REQ = r_nwait;

endmodule

// File: tb/tb_vdp_strobe.sv
// Directed bench for vdp_strobe: default instance (recovery 48) and a
// RECOVERY_CYCLES=1 instance share the same bus stimulus.
// Nominal E cycle used here: phases 0..15, nQ low 4..11, nE low 8..15, so a
// hit strobes from the phase-4 edge until the next phase-0 edge.
module tb_vdp_strobe;

  logic        clk;
  logic        rst;
  logic        ne;
  logic        nq;
  logic [15:0] addr;
  logic        rnw;

  logic        d0_ncsr, d0_ncsw, d0_nwait;
  logic [1:0]  d0_mode;
  logic        d1_ncsr, d1_ncsw, d1_nwait;
  logic [1:0]  d1_mode;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ne;
    logic        nq;
    logic [15:0] addr;
    logic        rnw;
    int          n;
    logic        ncsr;
    logic        ncsw;
    logic        nwait;
    logic [1:0]  mode;
  } seg_t;

  seg_t tbl [12];

  vdp_strobe dut0 (
    .MHZ48     (clk),
    .RESET     (rst),
    .nE        (ne),
    .nQ        (nq),
    .ADDR      (addr),
    .RnW       (rnw),
    .nCSR      (d0_ncsr),
    .nCSW      (d0_ncsw),
    .MODE      (d0_mode),
    .nWAIT_REQ (d0_nwait)
  );

  vdp_strobe #(.RECOVERY_CYCLES(1)) dut1 (
    .MHZ48     (clk),
    .RESET     (rst),
    .nE        (ne),
    .nQ        (nq),
    .ADDR      (addr),
    .RnW       (rnw),
    .nCSR      (d1_ncsr),
    .nCSW      (d1_ncsw),
    .MODE      (d1_mode),
    .nWAIT_REQ (d1_nwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: {nCSR,nCSW,nWAIT_REQ,MODE} got %b required %b",
               name, idx, act, exp);
    end
  endtask

  // Hold nE/nQ for n cycles, checking one instance after every rising edge.
  task automatic seg(input int sel, input string name, input logic e, input logic q,
                     input int n, input logic x_ncsr, input logic x_ncsw,
                     input logic x_nwait, input logic [1:0] x_mode);
    logic [4:0] act;
    for (int i = 0; i < n; i++) begin
      ne = e;
      nq = q;
      @(negedge clk);
      act = (sel == 0) ? {d0_ncsr, d0_ncsw, d0_nwait, d0_mode}
                       : {d1_ncsr, d1_ncsw, d1_nwait, d1_mode};
      check(name, i, act, {x_ncsr, x_ncsw, x_nwait, x_mode});
    end
  endtask

  initial begin
    // Single read FF61, then non-hits FF5F (read) and FF64 (write).
    tbl[0]  = '{1'b1, 1'b1, 16'hFF61, 1'b1, 4, 1'b1, 1'b1, 1'b1, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 16'hFF61, 1'b1, 4, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[2]  = '{1'b0, 1'b0, 16'hFF61, 1'b1, 4, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[3]  = '{1'b0, 1'b1, 16'hFF61, 1'b1, 4, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[4]  = '{1'b1, 1'b1, 16'hFF5F, 1'b1, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 16'hFF5F, 1'b1, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 16'hFF5F, 1'b1, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 16'hFF5F, 1'b1, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 1'b1, 16'hFF64, 1'b0, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{1'b1, 1'b0, 16'hFF64, 1'b0, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 16'hFF64, 1'b0, 4, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 1'b1, 16'hFF64, 1'b0, 4, 1'b1, 1'b1, 1'b1, 2'd1};

    rst  = 1'b1;
    ne   = 1'b1;
    nq   = 1'b1;
    addr = 16'h0000;
    rnw  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_d0", 0, {d0_ncsr, d0_ncsw, d0_nwait, d0_mode}, 5'b11100);
    check("reset_d1", 0, {d1_ncsr, d1_ncsw, d1_nwait, d1_mode}, 5'b11100);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      addr = tbl[r].addr;
      rnw  = tbl[r].rnw;
      seg(0, $sformatf("tbl%0d", r), tbl[r].ne, tbl[r].nq, tbl[r].n,
          tbl[r].ncsr, tbl[r].ncsw, tbl[r].nwait, tbl[r].mode);
    end

    // Let the recovery counter drain fully.
    seg(0, "drain1", 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b1, 2'd1);

    // Back-to-back writes to FF60; second Q rise lands 12 cycles after the
    // first strobe ends, so 48-12 = 36 wait cycles.
    addr = 16'hFF60;
    rnw  = 1'b0;
    seg(0, "b2b_w1_q",   1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(0, "b2b_w1_e",   1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(0, "b2b_w1_qf",  1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(0, "b2b_w1_end", 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd0);
    seg(0, "b2b_gap",    1'b1, 1'b1, 11, 1'b1, 1'b1, 1'b1, 2'd0);
    seg(0, "b2b_detect", 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 2'd0);
    // Bus lines wander during the stall; latched MODE/RnW must hold.
    addr = 16'hFF00;
    rnw  = 1'b1;
    seg(0, "b2b_wait_a", 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0, 2'd0);
    seg(0, "b2b_wait_b", 1'b0, 1'b0, 32, 1'b1, 1'b1, 1'b0, 2'd0);
    seg(0, "b2b_w2_rel", 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(0, "b2b_w2_qf",  1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(0, "b2b_w2_end", 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd0);

    // Abort: E falls while stalled (counter 48 loaded 4 cycles before the hit).
    seg(0, "abort_idle", 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 2'd0);
    addr = 16'hFF63;
    rnw  = 1'b1;
    seg(0, "abort_q",    1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'd3);
    seg(0, "abort_e",    1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'd3);
    seg(0, "abort_qf",   1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 2'd3);
    seg(0, "abort_efal", 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd3);
    seg(0, "abort_post", 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 2'd3);
    // Counter kept running from 44 (no reload): 44-16 = 28 wait cycles here.
    addr = 16'hFF61;
    seg(0, "cont_q",     1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'd1);
    seg(0, "cont_wait",  1'b0, 1'b0, 24, 1'b1, 1'b1, 1'b0, 2'd1);
    seg(0, "cont_rel",   1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'd1);
    seg(0, "cont_qf",    1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b1, 2'd1);
    seg(0, "cont_end",   1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd1);

    // Reset mid-strobe: async clear between clock edges.
    seg(0, "drain2", 1'b1, 1'b1, 50, 1'b1, 1'b1, 1'b1, 2'd1);
    addr = 16'hFF62;
    rnw  = 1'b0;
    seg(0, "rst_w_q", 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'd2);
    seg(0, "rst_w_e", 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'd2);
    #2;
    rst = 1'b1;
    ne  = 1'b1;
    nq  = 1'b1;
    #1;
    check("rst_async", 0, {d0_ncsr, d0_ncsw, d0_nwait, d0_mode}, 5'b11100);
    @(negedge clk);
    check("rst_held", 0, {d0_ncsr, d0_ncsw, d0_nwait, d0_mode}, 5'b11100);
    rst = 1'b0;
    addr = 16'hFF61;
    rnw  = 1'b1;
    seg(0, "post_rst_idle", 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b1, 2'd0);
    seg(0, "post_rst_q",    1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'd1);
    seg(0, "post_rst_e",    1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'd1);
    seg(0, "post_rst_qf",   1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b1, 2'd1);

    // RECOVERY_CYCLES=1 instance: hit 1 cycle after strobe end -> 1 wait cycle.
    seg(1, "r1_end",   1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd1);
    addr = 16'hFF60;
    rnw  = 1'b0;
    seg(1, "r1_wait",  1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 2'd0);
    seg(1, "r1_rel",   1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(1, "r1_e",     1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(1, "r1_qf",    1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 2'd0);
    seg(1, "r1_end2",  1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd0);
    // Hit 2 cycles after strobe end -> immediate strobe.
    seg(1, "r1_gap",   1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd0);
    addr = 16'hFF62;
    rnw  = 1'b1;
    seg(1, "r1_imm",   1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'd2);
    seg(1, "r1_imm_e", 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'd2);
    seg(1, "r1_imm_q", 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b1, 2'd2);
    seg(1, "r1_imm_x", 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
